// File: rtl/pcpi_link_pkg.sv
// Types and sizes shared by the PCPI nibble link (result transmit and instruction receive).
package pcpi_link_pkg;

    localparam int unsigned NIB_W   = 4;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned NIB_CNT = DATA_W / NIB_W;
    localparam int unsigned IDX_W   = $clog2(NIB_CNT);

    typedef logic [IDX_W-1:0] nib_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        PRESENT,
        RELEASE
    } link_state_e;

endpackage

// File: rtl/pcpi_result_nibble_tx_if.sv
// Off-chip nibble link: the transmitter drives nibble/req/idx/parity, the host returns ack.
interface pcpi_result_nibble_tx_if #(
    parameter int unsigned NIB_W = pcpi_link_pkg::NIB_W,
    parameter int unsigned IDX_W = pcpi_link_pkg::IDX_W
);

    logic [NIB_W-1:0] tx_nibble;
    logic             tx_req;
    logic [IDX_W-1:0] tx_idx;
    logic             tx_parity;
    logic             host_ack;

    modport master (
        output tx_nibble,
        output tx_req,
        output tx_idx,
        output tx_parity,
        input  host_ack
    );

    modport slave (
        input  tx_nibble,
        input  tx_req,
        input  tx_idx,
        input  tx_parity,
        output host_ack
    );

endinterface

// File: rtl/pcpi_sync_bit.sv
// Single-bit flop-chain synchronizer with asynchronous active-low reset.
module pcpi_sync_bit #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pcpi_result_nibble_tx.sv
// PCPI result serializer: sends a captured word as nibbles over a four-phase req/ack link.
// Optional TX_PARITY_EN builds a registered even-parity bit per nibble; otherwise tx_parity is 0.
module pcpi_result_nibble_tx
    import pcpi_link_pkg::link_state_e, pcpi_link_pkg::IDLE, pcpi_link_pkg::ARM,
           pcpi_link_pkg::PRESENT, pcpi_link_pkg::RELEASE;
#(
    parameter int unsigned DATA_W      = pcpi_link_pkg::DATA_W,
    parameter int unsigned NIB_W       = pcpi_link_pkg::NIB_W,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  res_valid,
    input  logic [DATA_W-1:0]     res_data,
    pcpi_result_nibble_tx_if.master link,
    output logic                  busy,
    output logic                  done,
    output logic                  overrun
);

    localparam int unsigned NIB_CNT = DATA_W / NIB_W;
    localparam int unsigned IDX_W   = $clog2(NIB_CNT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB_CNT - 1);

    logic              ack_s;
    link_state_e       state_q;
    logic [DATA_W-1:0] shift_q;
    logic [NIB_W-1:0]  nibble_q;
    logic              req_q;
    logic [IDX_W-1:0]  idx_q;
    logic              busy_q;
    logic              done_q;
    logic              overrun_q;
    logic              load_nib;

    pcpi_sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (link.host_ack),
        .q     (ack_s)
    );

    // A new nibble goes out when leaving ARM, or after a non-final handshake completes.
    always_comb begin
        load_nib = 1'b0;
        if (!ack_s) begin
            load_nib = (state_q == ARM) || ((state_q == RELEASE) && (idx_q != LAST_IDX));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            nibble_q  <= '0;
            req_q     <= 1'b0;
            idx_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (res_valid && busy_q) begin
                overrun_q <= 1'b1;
            end
            if (load_nib) begin
                nibble_q <= shift_q[NIB_W-1:0];
                shift_q  <= shift_q >> NIB_W;
                req_q    <= 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (res_valid) begin
                        shift_q <= res_data;
                        busy_q  <= 1'b1;
                        idx_q   <= '0;
                        state_q <= ARM;
                    end
                end
                ARM: begin
                    // Waiting here filters out an ack left high from a previous exchange.
                    if (!ack_s) begin
                        state_q <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (ack_s) begin
                        req_q   <= 1'b0;
                        state_q <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (!ack_s) begin
                        if (idx_q == LAST_IDX) begin
                            idx_q   <= '0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            idx_q   <= idx_q + 1'b1;
                            state_q <= PRESENT;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef TX_PARITY_EN
    logic parity_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_q <= 1'b0;
        end else if (load_nib) begin
            parity_q <= ^shift_q[NIB_W-1:0];
        end
    end

    assign link.tx_parity = parity_q;
`else
    assign link.tx_parity = 1'b0;
`endif

    assign link.tx_nibble = nibble_q;
    assign link.tx_req    = req_q;
    assign link.tx_idx    = idx_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign overrun        = overrun_q;

endmodule

// File: tb/tb_pcpi_result_nibble_tx.sv
// Self-checking bench for pcpi_result_nibble_tx: nibble-queue reference model plus a model host.
module tb_pcpi_result_nibble_tx;

    localparam int SYNC_STAGES = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        res_valid = 1'b0;
    logic [31:0] res_data = '0;
    logic        busy, done, overrun;

    pcpi_result_nibble_tx_if link ();

    pcpi_result_nibble_tx #(
        .DATA_W      (32),
        .NIB_W       (4),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .res_valid (res_valid),
        .res_data  (res_data),
        .link      (link),
        .busy      (busy),
        .done      (done),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // Reference model: nibbles still owed for the word in flight.
    logic [3:0]  exp_q[$];
    bit          in_flight = 0;
    bit          ovr_m = 0;
    int          done_cd = -1;
    bit          drv_rv = 0;
    logic [31:0] drv_rd = '0;
    bit          rv_next = 0;
    logic [31:0] rd_next = '0;
    bit          b2b_arm = 0;
    logic [31:0] b2b_data = '0;
    bit          stale_hold = 0;
    int          ack_delay = 3;
    int          wait_cnt = 0;
    bit          prev_req = 0;
    int          dones_seen = 0;
    logic [7:0]  cap[$];

    function automatic logic exp_par(input logic [3:0] n);
`ifdef TX_PARITY_EN
        return ^n;
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    endtask

    // One cycle: apply last edge to the model, compare, run the host, drive next inputs.
    task automatic tick();
        bit exp_done;
        @(negedge clk);
        if (drv_rv && rst_n) begin
            if (!in_flight) begin
                for (int i = 0; i < 8; i++) exp_q.push_back(drv_rd[i*4 +: 4]);
                in_flight = 1;
            end else begin
                ovr_m = 1;
            end
        end
        exp_done = 0;
        if (done_cd > 0) begin
            done_cd--;
            if (done_cd == 0) begin
                exp_done  = 1;
                in_flight = 0;
                done_cd   = -1;
            end
        end
        chk("busy", busy, in_flight);
        chk("done", done, exp_done);
        chk("overrun", overrun, ovr_m);
        if (done) dones_seen++;
        if (link.tx_req) begin
            if (exp_q.size() == 0) begin
                chk("req_without_word", 1, 0);
            end else begin
                chk("nibble", link.tx_nibble, exp_q[0]);
                chk("idx", link.tx_idx, 8 - exp_q.size());
                chk("parity", link.tx_parity, exp_par(exp_q[0]));
            end
            if (!prev_req) cap.push_back({link.tx_parity, link.tx_idx, link.tx_nibble});
        end
        prev_req = link.tx_req;
        if (stale_hold) begin
            link.host_ack = 1'b1;
        end else if (link.tx_req && !link.host_ack) begin
            if (wait_cnt >= ack_delay) begin
                link.host_ack = 1'b1;
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end else if (!link.tx_req && link.host_ack) begin
            link.host_ack = 1'b0;
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            if (exp_q.size() == 0) done_cd = SYNC_STAGES + 1;
        end
        if (b2b_arm && exp_done) begin
            rv_next = 1;
            rd_next = b2b_data;
            b2b_arm = 0;
        end
        drv_rv    = rv_next;
        drv_rd    = rd_next;
        res_valid = rv_next;
        res_data  = rv_next ? rd_next : $urandom();
        rv_next   = 0;
    endtask

    task automatic send(input logic [31:0] w);
        rv_next = 1;
        rd_next = w;
        tick();
    endtask

    task automatic wait_idle(input int budget, input bit inject);
        int n = 0;
        tick();
        while ((in_flight || exp_q.size() > 0) && n < budget) begin
            if (inject && $urandom_range(29) == 0) begin
                rv_next = 1;
                rd_next = $urandom();
            end
            tick();
            n++;
        end
        chk("word_finished_in_budget", (n < budget), 1);
    endtask

    task automatic wait_nib(input int idx);
        int n = 0;
        while (!(link.tx_req && link.tx_idx == idx) && n < 300) begin
            tick();
            n++;
        end
        chk("reached_nibble", (n < 300), 1);
    endtask

    task automatic chk_out_zero(input string tag);
        chk({tag, "_req"}, link.tx_req, 0);
        chk({tag, "_nibble"}, link.tx_nibble, 0);
        chk({tag, "_idx"}, link.tx_idx, 0);
        chk({tag, "_parity"}, link.tx_parity, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_overrun"}, overrun, 0);
    endtask

    task automatic model_reset();
        exp_q.delete();
        in_flight = 0; ovr_m = 0; done_cd = -1;
        drv_rv = 0; rv_next = 0; b2b_arm = 0; stale_hold = 0;
        wait_cnt = 0; prev_req = 0;
        link.host_ack = 1'b0;
        res_valid = 1'b0;
    endtask

    task automatic chk_cap(input string tag, input int base, input logic [3:0] nib[8],
                           input logic par[8]);
        chk({tag, "_count"}, (cap.size() >= base + 8), 1);
        for (int i = 0; i < 8; i++) begin
            if (cap.size() > base + i) begin
                chk({tag, "_nib"}, cap[base+i][3:0], nib[i]);
                chk({tag, "_idx"}, cap[base+i][6:4], i);
                chk({tag, "_par"}, cap[base+i][7], par[i]);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] lit[8];
        logic       par0[8];
        logic       parl[8];
        int         d0;
        int         n;
        par0 = '{0, 0, 0, 0, 0, 0, 0, 0};
        link.host_ack = 1'b0;

        // Reset state.
        repeat (3) tick();
        chk_out_zero("reset");
        rst_n = 1'b1;
        repeat (2) tick();

        // Single word, host acks after 3 cycles.
        cap.delete();
        d0 = dones_seen;
        send(32'h89ABCDEF);
        wait_idle(400, 0);
        lit = '{4'hF, 4'hE, 4'hD, 4'hC, 4'hB, 4'hA, 4'h9, 4'h8};
        chk_cap("w1", 0, lit, par0);
        chk("w1_done_count", dones_seen - d0, 1);
        tick();
        chk("w1_busy_after", busy, 0);
        chk("w1_overrun", overrun, 0);

        // Stale ack held high across capture.
        cap.delete();
        stale_hold = 1;
        link.host_ack = 1'b1;
        send(32'h00000005);
        repeat (8) begin
            tick();
            chk("stale_req_low", link.tx_req, 0);
        end
        stale_hold = 0;
        link.host_ack = 1'b0;
        ack_delay = 12;
        n = 0;
        while (!link.tx_req && n < 20) begin
            tick();
            n++;
        end
        chk("stale_req_rises", link.tx_req, 1);
        chk("stale_first_nib", cap.size() > 0 ? cap[0] : 8'hFF, 8'h05);
        repeat (6) tick();
        chk("stale_not_consumed_req", link.tx_req, 1);
        chk("stale_not_consumed_idx", link.tx_idx, 0);
        ack_delay = 3;
        wait_idle(600, 0);

        // Overrun during nibble 3.
        cap.delete();
        send(32'h11111111);
        wait_nib(3);
        rv_next = 1;
        rd_next = 32'h22222222;
        wait_idle(400, 0);
        lit = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1};
        parl = '{exp_par(4'h1), exp_par(4'h1), exp_par(4'h1), exp_par(4'h1),
                 exp_par(4'h1), exp_par(4'h1), exp_par(4'h1), exp_par(4'h1)};
        chk_cap("ovr", 0, lit, parl);
        repeat (3) tick();
        chk("ovr_sticky", overrun, 1);

        // Back-to-back: second word offered in the done cycle.
        cap.delete();
        b2b_arm = 1;
        b2b_data = 32'h0F0F0F0F;
        send(32'h13579BDF);
        wait_idle(400, 0);
        tick();
        chk("b2b_busy", busy, 1);
        wait_idle(400, 0);
        lit = '{4'hF, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0};
        parl = '{exp_par(4'hF), 0, exp_par(4'hF), 0, exp_par(4'hF), 0, exp_par(4'hF), 0};
        chk_cap("b2b", 8, lit, parl);

        // Asynchronous reset during nibble 4.
        send(32'hDEADBEEF);
        wait_nib(4);
        d0 = dones_seen;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_out_zero("midrst");
        model_reset();
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        chk("midrst_no_done", dones_seen - d0, 0);
        cap.delete();
        send(32'h12345678);
        wait_idle(400, 0);
        lit = '{4'h8, 4'h7, 4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1};
        parl = '{exp_par(4'h8), exp_par(4'h7), exp_par(4'h6), exp_par(4'h5),
                 exp_par(4'h4), exp_par(4'h3), exp_par(4'h2), exp_par(4'h1)};
        chk_cap("after_rst", 0, lit, parl);

        // Parity pattern; nibbles 0,1,3,7 then zeros.
        cap.delete();
        send(32'h00007310);
        wait_idle(400, 0);
        lit = '{4'h0, 4'h1, 4'h3, 4'h7, 4'h0, 4'h0, 4'h0, 4'h0};
`ifdef TX_PARITY_EN
        parl = '{0, 1, 0, 1, 0, 0, 0, 0};
`else
        parl = par0;
`endif
        chk_cap("par", 0, lit, parl);

        // Randomized words, ack timing and stray res_valid pulses.
        for (int k = 0; k < 25; k++) begin
            ack_delay = $urandom_range(5);
            send($urandom());
            wait_idle(600, 1);
        end
        ack_delay = 3;
        wait_idle(600, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
